// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register file's single write port (WE3/AD3/WD3).
// Load results normally win; a pending ALU result is forced through after STARVE_LIMIT losses.
module regfile_wb_arbiter #(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int STARVE_LIMIT  = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wb_hold,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [ADDRESS_WIDTH-1:0] alu_rd,
    input  logic [DATA_WIDTH-1:0]    alu_data,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [ADDRESS_WIDTH-1:0] mem_rd,
    input  logic [DATA_WIDTH-1:0]    mem_data,
    output logic                     WE3,
    output logic [ADDRESS_WIDTH-1:0] AD3,
    output logic [DATA_WIDTH-1:0]    WD3,
    output logic [1:0]               grant,
    output logic [3:0]               starve_cnt
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    logic                     we_q, we_d;
    logic [ADDRESS_WIDTH-1:0] ad_q, ad_d;
    logic [DATA_WIDTH-1:0]    wd_q, wd_d;
    logic [1:0]               grant_q, grant_d;
    logic [3:0]               starve_q, starve_d;
    logic                     alu_win, mem_win;

    always_comb begin
        alu_win = 1'b0;
        mem_win = 1'b0;
        if (!wb_hold && !rst) begin
            alu_win = alu_valid && (!mem_valid || starve_q == LIMIT);
            mem_win = mem_valid && !alu_win;
        end
    end

    assign alu_ready = alu_win;
    assign mem_ready = mem_win;

    // Losing cycles count even while frozen, so a hold can push the ALU to its forced slot.
    always_comb begin
        starve_d = 4'd0;
        if (alu_valid && !alu_win) begin
            starve_d = (starve_q >= LIMIT) ? LIMIT : starve_q + 4'd1;
        end
    end

    always_comb begin
        we_d    = 1'b0;
        ad_d    = ad_q;
        wd_d    = wd_q;
        grant_d = grant_q;
        if (alu_win) begin
            we_d    = (alu_rd != '0);
            ad_d    = alu_rd;
            wd_d    = alu_data;
            grant_d = 2'b01;
        end else if (mem_win) begin
            we_d    = (mem_rd != '0);
            ad_d    = mem_rd;
            wd_d    = mem_data;
            grant_d = 2'b10;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            ad_q     <= '0;
            wd_q     <= '0;
            grant_q  <= 2'b00;
            starve_q <= 4'd0;
        end else begin
            we_q     <= we_d;
            ad_q     <= ad_d;
            wd_q     <= wd_d;
            grant_q  <= grant_d;
            starve_q <= starve_d;
        end
    end

    assign WE3        = we_q;
    assign AD3        = ad_q;
    assign WD3        = wd_q;
    assign grant      = grant_q;
    assign starve_cnt = starve_q;

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter for the 32-entry register file's single synchronous write port (WE3/AD3/WD3). Two requesters, the ALU result path and the load/memory result path, compete for the write port each cycle. The arbiter grants one request per cycle with valid/ready handshakes, bounds ALU starvation with a saturating counter, and discards writes to x0. It drives the write port from registered outputs.

## Interface
Parameters:
- ADDRESS_WIDTH, 5, register index width
- DATA_WIDTH, 32, write data width
- STARVE_LIMIT, 3, maximum consecutive cycles a pending ALU request may lose before it is forced to win; legal range 1..15

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- wb_hold  in  1  freeze: while high, no grants are issued
- alu_valid  in  1  ALU write-back request
- alu_ready  out  1  ALU request accepted this cycle (combinational)
- alu_rd  in  ADDRESS_WIDTH  ALU destination register
- alu_data  in  DATA_WIDTH  ALU result
- mem_valid  in  1  load write-back request
- mem_ready  out  1  load request accepted this cycle (combinational)
- mem_rd  in  ADDRESS_WIDTH  load destination register
- mem_data  in  DATA_WIDTH  load result
- WE3  out  1  register file write enable (registered)
- AD3  out  ADDRESS_WIDTH  register file write address (registered)
- WD3  out  DATA_WIDTH  register file write data (registered)
- grant  out  2  one-hot record of the last accepted source, {mem,alu} (registered)
- starve_cnt  out  4  current ALU starvation count (registered)

## Operation
- Handshake: a transfer occurs when valid && ready in the same cycle. At most one ready is high per cycle.
  - Requesters must hold rd/data stable while valid is high and ready is low.
  - A requester may drop valid without a transfer.
- Grant selection (combinational) when wb_hold=0 and rst=0:
  - mem_valid=0 and alu_valid=1: ALU wins.
  - mem_valid=1 and alu_valid=0: MEM wins.
  - Both valid and starve_cnt==STARVE_LIMIT: ALU wins (forced).
  - Both valid and starve_cnt<STARVE_LIMIT: MEM wins.
  - Neither valid: no grant.
- wb_hold=1 or rst=1: alu_ready=mem_ready=0.
- Starvation counter, updated at the clock edge:
  - Clears to 0 if the ALU was granted or alu_valid=0.
  - Increments by 1 if alu_valid=1 and the ALU was not granted, including cycles with wb_hold=1.
  - Saturates at STARVE_LIMIT.
- Output stage, on the edge after a transfer:
  - AD3 and WD3 load the winner's rd and data.
  - grant loads the winner's one-hot code.
  - WE3=1 only if the winner's rd != 0. A transfer with rd==0 completes the handshake with WE3=0 (x0 stays zero).
- With no transfer: WE3=0 on the next edge, while AD3, WD3 and grant hold their previous values.

## Timing
- Reset values: WE3=0, AD3=0, WD3=0, grant=2'b00, starve_cnt=0. Combinationally, alu_ready=mem_ready=0 while rst=1.
- Reset asserted mid-operation: all registered outputs clear immediately (asynchronous). Any transfer in that cycle is lost.
- Latency:
  - Handshake in cycle N gives WE3=1 during cycle N+1.
  - The register file commits at the end of N+1.
  - The new value is visible on the register file's asynchronous read ports from cycle N+2.
- Throughput is one write per cycle. Back-to-back transfers produce WE3 high in consecutive cycles.
- If wb_hold is asserted in cycle N, then WE3=0 in N+1. The pending requests are retained by the requesters (valid stays high) and served after wb_hold deasserts.
- Same-cycle requests to the same rd from both sources are arbitrated normally. The loser writes in a later cycle, so the last write to the register file wins.
- Worst-case ALU wait with mem_valid held high continuously is STARVE_LIMIT cycles; it is granted on cycle STARVE_LIMIT+1.

## Test plan
- Reset: assert rst mid-stream while WE3=1 and AD3=7 -> WE3=0, AD3=0, WD3=0, grant=00 and starve_cnt=0 immediately; both readies 0 until rst drops.
- Single ALU write: alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF in cycle N -> alu_ready=1 in N; WE3=1, AD3=5, WD3=DEADBEEF, grant=01 in N+1; WE3=0 in N+2.
- Priority and starvation, STARVE_LIMIT=3: hold both valid with mem_rd=1..4 across successive cycles and alu_rd=9 -> MEM granted 3 times (starve_cnt 1,2,3), ALU granted on the 4th cycle, then starve_cnt=0 and MEM resumes.
- x0 discard: mem_valid=1, mem_rd=0, mem_data=32'h1234 -> mem_ready=1; next cycle WE3=0, grant=10.
- Hold: both valid, wb_hold=1 for 2 cycles -> no readies, WE3=0, starve_cnt goes 1 then 2; on release MEM is granted, and ALU is forced on the following cycle (starve_cnt reached 3).
- Back-to-back: alu_valid alone for 4 cycles with rd=10..13 -> WE3 high for 4 consecutive cycles, AD3 sequence 10,11,12,13.
